// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite response codes, latency counter width and slave state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Latency counter width; RD_LAT/WR_LAT are limited to 1..15.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_DATA,
        WR_WAIT,
        WR_RESP
    } state_t;

endpackage

// File: rtl/sram_array.sv
// Word-organised storage with one byte-enabled write port and one read port.
module sram_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4096
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(DEPTH)-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [DATA_WIDTH/8-1:0]     wstrb,
    output logic [DATA_WIDTH-1:0]       rdata_c
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane write; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (wstrb[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Asynchronous read; the controller registers the result before it leaves the block.
    assign rdata_c = mem[addr];

endmodule

// File: rtl/axi_lite_sram.sv
// AXI-lite memory slave serving one transaction at a time with fixed read/write latency.
module axi_lite_sram
    import axi_lite_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h8000_0000),
    parameter int unsigned           RD_LAT     = 2,
    parameter int unsigned           WR_LAT     = 2
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      arvalid,
    output logic                      arready,
    input  logic [ADDR_WIDTH-1:0]     araddr,

    output logic                      rvalid,
    input  logic                      rready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,

    input  logic                      awvalid,
    output logic                      awready,
    input  logic [ADDR_WIDTH-1:0]     awaddr,

    input  logic                      wvalid,
    output logic                      wready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,

    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp
);

    localparam int unsigned   STRB_W = DATA_WIDTH / 8;
    localparam int unsigned   OFF_W  = $clog2(STRB_W);
    localparam int unsigned   IDX_W  = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_LAT - 1);

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [IDX_W-1:0]      idx, idx_n;
    logic                  ok, ok_n;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
    logic [STRB_W-1:0]     wstrb_q, wstrb_n;

    logic                  arready_n, awready_n, wready_n, rvalid_n, bvalid_n;
    logic [DATA_WIDTH-1:0] rdata_n;
    logic [1:0]            rresp_n, bresp_n;

    logic [ADDR_WIDTH-1:0] dec_addr_c, dec_word_c;
    logic [IDX_W-1:0]      dec_idx_c;
    logic                  dec_ok_c;
    logic                  mem_we_c;
    logic [DATA_WIDTH-1:0] mem_rdata_c;

    sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk     (clk),
        .we      (mem_we_c),
        .addr    (idx),
        .wdata   (wdata_q),
        .wstrb   (wstrb_q),
        .rdata_c (mem_rdata_c)
    );

    // Decode the address of the request that would win in IDLE (write has priority).
    always_comb begin
        dec_addr_c = awvalid ? awaddr : araddr;
        dec_word_c = (dec_addr_c - BASE_ADDR) >> OFF_W;
        dec_ok_c   = (dec_addr_c >= BASE_ADDR) && (dec_word_c < ADDR_WIDTH'(DEPTH));
        dec_idx_c  = dec_word_c[IDX_W-1:0];
    end

    // Next-state, datapath capture and registered-output next values.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        ok_n      = ok;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        rvalid_n  = rvalid;
        rdata_n   = rdata;
        rresp_n   = rresp;
        bvalid_n  = bvalid;
        bresp_n   = bresp;
        mem_we_c  = 1'b0;

        unique case (state)
            IDLE: begin
                if (awvalid && awready) begin
                    idx_n   = dec_idx_c;
                    ok_n    = dec_ok_c;
                    state_n = WR_DATA;
                end else if (arvalid && arready && !awvalid) begin
                    idx_n   = dec_idx_c;
                    ok_n    = dec_ok_c;
                    cnt_n   = RD_CNT;
                    state_n = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    rvalid_n = 1'b1;
                    rdata_n  = ok ? mem_rdata_c : '0;
                    rresp_n  = ok ? RESP_OKAY : RESP_SLVERR;
                    state_n  = RD_RESP;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RD_RESP: begin
                if (rready) begin
                    rvalid_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            WR_DATA: begin
                if (wvalid && wready) begin
                    wdata_n = wdata;
                    wstrb_n = wstrb;
                    cnt_n   = WR_CNT;
                    state_n = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (cnt == '0) begin
                    mem_we_c = ok;
                    bvalid_n = 1'b1;
                    bresp_n  = ok ? RESP_OKAY : RESP_SLVERR;
                    state_n  = WR_RESP;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            WR_RESP: begin
                if (bready) begin
                    bvalid_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Readiness follows the state being entered; a pending write masks arready.
        arready_n = (state_n == IDLE) && !awvalid;
        awready_n = (state_n == IDLE);
        wready_n  = (state_n == WR_DATA);
    end

    // State, counter, datapath and output registers; async reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            ok      <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            arready <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
            bvalid  <= 1'b0;
            bresp   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            ok      <= ok_n;
            wdata_q <= wdata_n;
            wstrb_q <= wstrb_n;
            arready <= arready_n;
            awready <= awready_n;
            wready  <= wready_n;
            rvalid  <= rvalid_n;
            rdata   <= rdata_n;
            rresp   <= rresp_n;
            bvalid  <= bvalid_n;
            bresp   <= bresp_n;
        end
    end

endmodule
